// File: rtl/jp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jp_pkg
// Brief    : Shared constants and types for the NES joypad scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package jp_pkg;

    // Button positions in the published bytes (1 = pressed)
    localparam int JP_A      = 0;
    localparam int JP_B      = 1;
    localparam int JP_SELECT = 2;
    localparam int JP_START  = 3;
    localparam int JP_UP     = 4;
    localparam int JP_DOWN   = 5;
    localparam int JP_LEFT   = 6;
    localparam int JP_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } jp_state_t;

    // Busy length of one poll: 2 latch half-periods plus 8 low/high pairs
    function automatic int poll_cycles(input int clk_div);
        return 18 * clk_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jp_sync.sv
`default_nettype none
// ============================================================================
// Module   : jp_sync
// Brief    : Two-flop synchronizer for a pad data line; resets to released (1).
// Revision : 1.0 - initial release
// ============================================================================
module jp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/jp_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jp_poll_ctrl
// Brief    : Periodic NES joypad scanner for both ports with presence tracking.
// Revision : 1.0 - initial release
// ============================================================================
module jp_poll_ctrl
    import jp_pkg::*;
#(
    parameter int CLK_DIV     = 150,
    parameter int POLL_PERIOD = 416667
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       jp_data1,
    input  logic       jp_data2,
    output logic       jp_clk,
    output logic       jp_latch,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic [1:0] present,
    output logic       valid,
    output logic       busy
);

    localparam int                c_div_w    = $clog2(CLK_DIV);
    localparam int                c_poll_w   = $clog2(POLL_PERIOD);
    localparam logic [c_div_w-1:0]  c_div_max  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_poll_w-1:0] c_poll_max = c_poll_w'(POLL_PERIOD - 1);

    jp_state_t             r_state;
    jp_state_t             w_state_next;
    logic [c_div_w-1:0]    r_div;
    logic                  r_latch_half;
    logic [2:0]            r_bit;
    logic [7:0]            r_shadow1;
    logic [7:0]            r_shadow2;
    logic [c_poll_w-1:0]   r_poll_cnt;
    logic                  w_d1;
    logic                  w_d2;
    logic                  w_div_last;
    logic                  w_trigger;
    logic                  w_busy_next;
    logic [1:0]            w_present_new;

    jp_sync u_sync1 (.clk(clk), .rst_n(rst_n), .d(jp_data1), .q(w_d1));
    jp_sync u_sync2 (.clk(clk), .rst_n(rst_n), .d(jp_data2), .q(w_d2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= (r_poll_cnt == c_poll_max) ? '0 : r_poll_cnt + 1'b1;
        end
    end

    assign w_div_last    = (r_div == '0);
    assign w_trigger     = (r_poll_cnt == c_poll_max) || start;
    assign w_busy_next   = (w_state_next == ST_LATCH) || (w_state_next == ST_CLK_LO) ||
                           (w_state_next == ST_CLK_HI);
    assign w_present_new = present | {~&r_shadow2, ~&r_shadow1};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_trigger) w_state_next = ST_LATCH;
            ST_LATCH:  if (w_div_last && r_latch_half) w_state_next = ST_CLK_LO;
            ST_CLK_LO: if (w_div_last) w_state_next = ST_CLK_HI;
            ST_CLK_HI: if (w_div_last) w_state_next = (r_bit == 3'd7) ? ST_DONE : ST_CLK_LO;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_div        <= c_div_max;
            r_latch_half <= 1'b0;
            r_bit        <= 3'd0;
            r_shadow1    <= '1;
            r_shadow2    <= '1;
            jp_clk       <= 1'b0;
            jp_latch     <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            buttons1     <= 8'h00;
            buttons2     <= 8'h00;
            present      <= 2'b00;
        end else begin
            r_state <= w_state_next;

            if ((w_state_next != r_state) || w_div_last || (r_state == ST_IDLE)) begin
                r_div <= c_div_max;
            end else begin
                r_div <= r_div - 1'b1;
            end

            // The latch phase is two half-periods long; this flag marks the second one
            if ((r_state == ST_LATCH) && w_div_last) begin
                r_latch_half <= ~r_latch_half;
            end

            if (r_state == ST_LATCH) begin
                r_bit <= 3'd0;
            end else if ((r_state == ST_CLK_HI) && w_div_last) begin
                r_bit <= r_bit + 3'd1;
            end

            if ((r_state == ST_CLK_LO) && w_div_last) begin
                r_shadow1[r_bit] <= w_d1;
                r_shadow2[r_bit] <= w_d2;
            end

            jp_latch <= (w_state_next == ST_LATCH);
            jp_clk   <= (w_state_next == ST_CLK_HI);
            busy     <= w_busy_next;
            valid    <= (w_state_next == ST_DONE);

            if (w_state_next == ST_DONE) begin
                present  <= w_present_new;
                buttons1 <= w_present_new[0] ? ~r_shadow1 : 8'h00;
                buttons2 <= w_present_new[1] ? ~r_shadow2 : 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jp_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jp_poll_ctrl
// Brief    : Self-checking bench for jp_poll_ctrl with a cycle-offset reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jp_poll_ctrl;
    import jp_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 200;
    localparam int c_busy      = poll_cycles(CLK_DIV);

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       jp_data1 = 1'b1;
    logic       jp_data2 = 1'b1;
    logic       jp_clk;
    logic       jp_latch;
    logic [7:0] buttons1;
    logic [7:0] buttons2;
    logic [1:0] present;
    logic       valid;
    logic       busy;

    int total  = 0;
    int bad    = 0;
    int vcount = 0;

    jp_poll_ctrl #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .jp_data1(jp_data1), .jp_data2(jp_data2),
        .jp_clk(jp_clk), .jp_latch(jp_latch),
        .buttons1(buttons1), .buttons2(buttons2),
        .present(present), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: n = active edges since reset release, t0 = edge that started a poll
    int   n  = 0;
    int   t0 = -1;
    bit   h1 [0:8191];
    bit   h2 [0:8191];
    logic p_rst = 1'b0, p_d1 = 1'b1, p_d2 = 1'b1, p_start = 1'b0;
    logic [7:0] m_b1 = 8'h00, m_b2 = 8'h00;
    logic [1:0] m_pres = 2'b00;

    initial begin : compare
        logic [21:0] got, exp;
        logic [7:0]  s1, s2;
        logic        e_clk, e_latch, e_busy, e_valid;
        int          k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n = 0; t0 = -1; m_b1 = 8'h00; m_b2 = 8'h00; m_pres = 2'b00; p_rst = 1'b0;
            end else begin
                if (p_rst) begin
                    n++;
                    if (n < 8192) begin h1[n] = p_d1; h2[n] = p_d2; end
                    if ((t0 < 0 || n - t0 >= c_busy + 2) &&
                        (((n - 1) % POLL_PERIOD) == POLL_PERIOD - 1 || p_start))
                        t0 = n;
                end
                p_rst = 1'b1;
            end
            p_d1 = jp_data1; p_d2 = jp_data2; p_start = start;

            e_clk = 1'b0; e_latch = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
            k = (t0 >= 0) ? n - t0 : -1;
            if (rst_n && k >= 0 && k < c_busy) begin
                e_busy  = 1'b1;
                e_latch = (k < 2 * CLK_DIV);
                e_clk   = (k >= 2 * CLK_DIV) && ((((k - 2 * CLK_DIV) / CLK_DIV) % 2) == 1);
            end
            if (rst_n && k == c_busy) begin
                e_valid = 1'b1;
                // Bit i is what the line held two edges before the end of its low phase
                for (int i = 0; i < 8; i++) begin
                    s1[i] = h1[t0 + 3 * CLK_DIV - 2 + 2 * CLK_DIV * i];
                    s2[i] = h2[t0 + 3 * CLK_DIV - 2 + 2 * CLK_DIV * i];
                end
                if (s1 != 8'hFF) m_pres[0] = 1'b1;
                if (s2 != 8'hFF) m_pres[1] = 1'b1;
                m_b1 = m_pres[0] ? ~s1 : 8'h00;
                m_b2 = m_pres[1] ? ~s2 : 8'h00;
            end

            exp = {e_clk, e_latch, e_busy, e_valid, m_b1, m_b2, m_pres};
            got = {jp_clk, jp_latch, busy, valid, buttons1, buttons2, present};
            total++;
            if (got !== exp) begin
                bad++;
                if (bad <= 20) $display("FAIL cycle_compare edge=%0d got=%h exp=%h", n, got, exp);
            end
            if (valid === 1'b1) vcount++;
        end
    end

    // Stimulus side: mode 0 = shift-register pad model, 1 = random lines, 2 = manual
    int         ecount = 0;
    int         mode   = 0;
    int         idx    = 8;
    logic       pclk   = 1'b0;
    logic [7:0] pad1   = 8'hFF;
    logic [7:0] pad2   = 8'hFF;

    task automatic step();
        @(posedge clk);
        if (rst_n) ecount++;
        #1;
        if (jp_latch) idx = 0;
        else if (jp_clk && !pclk && idx < 8) idx++;
        pclk = jp_clk;
        if (mode == 1) begin
            jp_data1 = 1'($urandom);
            jp_data2 = 1'($urandom);
        end else if (mode == 0) begin
            jp_data1 = (idx < 8) ? pad1[3'(idx)] : 1'b1;
            jp_data2 = (idx < 8) ? pad2[3'(idx)] : 1'b1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int c;
        c = 0;
        while (valid !== 1'b1 && c < budget) begin step(); c++; end
        chk(name, 32'(valid), 1);
    endtask

    initial begin : stim
        int cnt, v0;
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 32'({jp_clk, jp_latch, busy, valid, buttons1, buttons2, present}), 0);

        // Auto poll: pad 1 presses A and Start, pad 2 absent
        pad1 = 8'hF6; pad2 = 8'hFF;
        rst_n = 1'b1; ecount = 0;
        cnt = 0;
        while (jp_latch !== 1'b1 && cnt < 400) begin step(); cnt++; end
        chk("first_latch_edge", ecount, POLL_PERIOD);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin cnt++; step(); end
        chk("busy_len", cnt, c_busy);
        chk("valid_high", 32'(valid), 1);
        chk("buttons1_a_start", 32'(buttons1), (1 << JP_A) | (1 << JP_START));
        chk("buttons2_absent", 32'(buttons2), 0);
        chk("present_p1", 32'(present), 1);
        step();
        chk("valid_one_cycle", 32'(valid), 0);

        // Manual start, a start while busy, and all buttons released on pad 1
        pad1 = 8'hFF;
        repeat (5) step();
        start = 1'b1; step(); start = 1'b0;
        chk("start_latch_next", 32'(jp_latch), 1);
        v0 = vcount;
        repeat (10) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (100) step();
        chk("busy_start_ignored", vcount - v0, 1);
        chk("sticky_present", 32'(present), 1);
        chk("released_buttons1", 32'(buttons1), 0);

        // Start on the same cycle as the counter trigger
        cnt = 0;
        while ((ecount % POLL_PERIOD) != POLL_PERIOD - 1 && cnt < 400) begin step(); cnt++; end
        v0 = vcount;
        start = 1'b1; step(); start = 1'b0;
        chk("coincident_latch", 32'(jp_latch), 1);
        repeat (120) step();
        chk("coincident_one_poll", vcount - v0, 1);

        // Reset in the fifth high phase of jp_clk
        start = 1'b1; step(); start = 1'b0;
        repeat (46) step();
        chk("clk_hi_before_reset", 32'(jp_clk), 1);
        v0 = vcount;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 32'({jp_clk, jp_latch, busy, valid, buttons1, buttons2, present}), 0);
        repeat (30) step();
        chk("no_valid_in_reset", vcount - v0, 0);

        pad1 = 8'hFF; pad2 = 8'h7F;
        rst_n = 1'b1; ecount = 0;
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;
        wait_valid("reset_poll_valid", 200);
        chk("buttons2_right", 32'(buttons2), 1 << JP_RIGHT);
        chk("present_p2_only", 32'(present), 2);
        chk("buttons1_after_reset", 32'(buttons1), 0);

        // Sampling point: bit 0 uses the line value two edges before its capture edge
        mode = 2; jp_data1 = 1'b1; jp_data2 = 1'b1;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (3 * CLK_DIV - 3) step();
        jp_data1 = 1'b0; step(); jp_data1 = 1'b1;
        wait_valid("sample_valid_a", 200);
        chk("sample_point_low", 32'(buttons1), 1 << JP_A);
        chk("sample_present_both", 32'(present), 3);

        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (3 * CLK_DIV - 2) step();
        jp_data1 = 1'b0; repeat (2) step(); jp_data1 = 1'b1;
        wait_valid("sample_valid_b", 200);
        chk("sample_late_change", 32'(buttons1), 0);

        // Random line activity with random start pulses
        mode = 1;
        for (int c = 0; c < 2500; c++) begin
            start = ($urandom_range(0, 49) == 0);
            step();
        end
        start = 1'b0;

        // Random button bytes through the pad model
        mode = 0;
        for (int p = 0; p < 6; p++) begin
            pad1 = 8'($urandom); pad2 = 8'($urandom);
            repeat (c_busy + 4) step();
            start = 1'b1; step(); start = 1'b0;
            repeat (c_busy + 4) step();
        end

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
